weight_feeder: RTL and testbench

//  Source end of the systolic-array weight shift chain. On start, it reads one weight tile from the weight buffer row by row.

---
 rtl/mmu_pkg.sv | 17 +
 rtl/weight_feeder.sv | 123 ++++++++++++
 tb/tb_weight_feeder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared constants and types for the 16x16 MMU and its weight feeder.
// RD_LAT is the weight-buffer read latency. The feeder's token pipe depth is derived from it.
package mmu_pkg;

   localparam int ROWS   = 16;
   localparam int COLS   = 16;
   localparam int DW     = 8;
   localparam int RD_LAT = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } feed_state_t;

endpackage

// File: rtl/weight_feeder.sv
// Streams one weight tile, bottom row first, from the weight buffer into the top-row PEs of every column.
// Beats past rows_valid are padded with zeros, so the shift chain always receives ROWS contiguous beats.
module weight_feeder
   import mmu_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [4:0]           rows_valid,
   output logic                 rd_en,
   output logic [AW-1:0]        rd_addr,
   input  logic [COLS*DW-1:0]   rd_data,
   output logic [COLS*DW-1:0]   win,
   output logic [COLS-1:0]      wwrite,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(ROWS) + 1;
   localparam int DRAIN_LEN = RD_LAT + 1;
   localparam logic [CW-1:0] LAST_BEAT  = CW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_LEN - 1);

   feed_state_t       state, state_next;
   logic [CW-1:0]     cnt, cnt_next;
   logic [AW-1:0]     base_q;
   logic [4:0]        rows_q;
   logic [4:0]        rows_eff;
   logic [CW-1:0]     row_idx;
   logic              issue_pad;
   logic [RD_LAT-1:0] tok_valid;
   logic [RD_LAT-1:0] tok_pad;

   assign rows_eff  = (rows_valid == 5'd0) ? 5'(ROWS) : rows_valid;
   assign row_idx   = LAST_BEAT - cnt;
   assign issue_pad = int'(row_idx) >= int'(rows_q);

   assign rd_en   = (state == ST_ISSUE) && !issue_pad;
   assign rd_addr = rd_en ? (base_q + AW'(row_idx)) : '0;
   assign busy    = (state == ST_ISSUE) || (state == ST_DRAIN);
   assign done    = (state == ST_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         base_q <= '0;
         rows_q <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (state == ST_IDLE && start) begin
            base_q <= base_addr;
            rows_q <= rows_eff;
         end
      end
   end

   // Start is only honoured from IDLE, which makes a start coincident with done wait one cycle.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_ISSUE;
               cnt_next   = '0;
            end
         end
         ST_ISSUE: begin
            if (cnt == LAST_BEAT) begin
               state_next = ST_DRAIN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (cnt == LAST_DRAIN) begin
               state_next = ST_DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Tokens ride alongside the read latency so each returning word meets its own pad flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tok_valid <= '0;
         tok_pad   <= '0;
         win       <= '0;
         wwrite    <= '0;
      end else begin
         tok_valid[0] <= (state == ST_ISSUE);
         tok_pad[0]   <= issue_pad;
         for (int i = 1; i < RD_LAT; i++) begin
            tok_valid[i] <= tok_valid[i-1];
            tok_pad[i]   <= tok_pad[i-1];
         end
         if (tok_valid[RD_LAT-1]) begin
            win    <= tok_pad[RD_LAT-1] ? '0 : rd_data;
            wwrite <= '1;
         end else begin
            win    <= '0;
            wwrite <= '0;
         end
      end
   end

endmodule

// File: tb/tb_weight_feeder.sv
// Scoreboard bench for weight_feeder: a memory model, a 16-row PE column model,
// and a negedge monitor comparing read, weight, done and busy activity against queued expectations.
module tb_weight_feeder;
   import mmu_pkg::*;

   localparam int AW = 8;

   typedef struct {
      int           cyc;
      logic [127:0] val;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [AW-1:0]        base_addr;
   logic [4:0]           rows_valid;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic [COLS*DW-1:0]   rd_data;
   logic [COLS*DW-1:0]   win;
   logic [COLS-1:0]      wwrite;
   logic                 busy;
   logic                 done;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   last_l = 0;
   bit   mixed = 1'b0;

   exp_t rd_q[$];
   exp_t win_q[$];
   int   done_q[$];
   int   busy_lo[$];
   int   busy_hi[$];

   logic           mem_req = 1'b0;
   logic [AW-1:0]  mem_addr = '0;
   logic [7:0]     pe [ROWS][COLS];

   weight_feeder #(.AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .rows_valid (rows_valid),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .win        (win),
      .wwrite     (wwrite),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] mem_row(input logic [7:0] a);
      logic [127:0] row;
      row = '0;
      for (int c = 0; c < COLS; c++) begin
         row[8*c +: 8] = mixed ? (a + 8'(c * 17)) : a;
      end
      return row;
   endfunction

   // Weight buffer with one cycle of read latency; idle cycles return junk so pad beats are tested.
   always @(negedge clk) begin
      mem_req  <= rd_en;
      mem_addr <= rd_addr;
   end

   always @(posedge clk) begin
      if (mem_req) rd_data <= mem_row(mem_addr);
      else         rd_data <= {8{16'hDEAD}};
   end

   always @(negedge clk) begin
      for (int c = 0; c < COLS; c++) begin
         if (wwrite[c]) begin
            for (int r = ROWS - 1; r > 0; r--) pe[r][c] <= pe[r-1][c];
            pe[0][c] <= win[8*c +: 8];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents activity, and flags overdue ones.
   always @(negedge clk) begin
      exp_t e;
      logic exp_busy;
      if (!reset) begin
         if (rd_en) begin
            if (rd_q.size() == 0) checkOutput("rd_unexpected", 128'(rd_addr), 128'h0);
            else begin
               e = rd_q.pop_front();
               checkOutput("rd_cycle", 128'(cyc), 128'(e.cyc));
               checkOutput("rd_addr", 128'(rd_addr), e.val);
            end
         end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
            e = rd_q.pop_front();
            checkOutput("rd_missing", 128'(0), 128'(e.cyc));
         end

         if (wwrite != '0) begin
            checkOutput("wwrite_all", 128'(wwrite), 128'(16'hFFFF));
            if (win_q.size() == 0) checkOutput("win_unexpected", win, 128'h0);
            else begin
               e = win_q.pop_front();
               checkOutput("win_cycle", 128'(cyc), 128'(e.cyc));
               checkOutput("win_data", win, e.val);
            end
         end else begin
            checkOutput("win_idle_zero", win, 128'h0);
            if (win_q.size() != 0 && win_q[0].cyc <= cyc) begin
               e = win_q.pop_front();
               checkOutput("win_missing", 128'(0), 128'(e.cyc));
            end
         end

         if (done) begin
            if (done_q.size() == 0) checkOutput("done_unexpected", 128'(1), 128'(0));
            else checkOutput("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
         end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
            checkOutput("done_missing", 128'(0), 128'(done_q.pop_front()));
         end

         exp_busy = 1'b0;
         foreach (busy_lo[i]) begin
            if (cyc >= busy_lo[i] && cyc <= busy_hi[i]) exp_busy = 1'b1;
         end
         checkOutput("busy", 128'(busy), 128'(exp_busy));
      end
   end

   task automatic pushLoad(input int l, input logic [7:0] base, input int rv);
      exp_t e;
      int r;
      logic [7:0] a;
      for (int k = 0; k < ROWS; k++) begin
         r = ROWS - 1 - k;
         a = base + 8'(r);
         if (r < rv) begin
            e.cyc = l + 1 + k;
            e.val = 128'(a);
            rd_q.push_back(e);
            e.val = mem_row(a);
         end else begin
            e.val = '0;
         end
         e.cyc = l + 3 + k;
         win_q.push_back(e);
      end
      done_q.push_back(l + 3 + ROWS);
      busy_lo.push_back(l + 1);
      busy_hi.push_back(l + 2 + ROWS);
   endtask

   task automatic applyStimulus(input logic [7:0] base, input logic [4:0] rv);
      @(negedge clk);
      start      = 1'b1;
      base_addr  = base;
      rows_valid = rv;
      last_l     = cyc;
      pushLoad(cyc, base, (rv == 5'd0) ? ROWS : int'(rv));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((rd_q.size() != 0 || win_q.size() != 0 || done_q.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("idle_timeout", 128'(1), 128'(0));
      repeat (2) @(negedge clk);
   endtask

   task automatic checkChain(input logic [7:0] base, input int rv);
      logic [127:0] row;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) row[8*c +: 8] = pe[r][c];
         checkOutput($sformatf("pe_row%0d", r), row, (r < rv) ? mem_row(base + 8'(r)) : 128'h0);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_rd_en"},   128'(rd_en),   128'h0);
      checkOutput({tag, "_rd_addr"}, 128'(rd_addr), 128'h0);
      checkOutput({tag, "_win"},     win,           128'h0);
      checkOutput({tag, "_wwrite"},  128'(wwrite),  128'h0);
      checkOutput({tag, "_busy"},    128'(busy),    128'h0);
      checkOutput({tag, "_done"},    128'(done),    128'h0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      rows_valid = '0;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] full tile, base 0x20");
      applyStimulus(8'h20, 5'd16);
      waitIdle();

      $display("[TB] padded tile, rows_valid 3");
      applyStimulus(8'h00, 5'd3);
      waitIdle();

      $display("[TB] address wrap, base 0xF8, rows_valid 0 meaning full");
      applyStimulus(8'hF8, 5'd0);
      waitIdle();

      $display("[TB] start held high across two loads");
      @(negedge clk);
      start      = 1'b1;
      base_addr  = 8'h40;
      rows_valid = 5'd16;
      pushLoad(cyc, 8'h40, ROWS);
      pushLoad(cyc + 20, 8'h40, ROWS);
      repeat (39) @(negedge clk);
      start = 1'b0;
      waitIdle();

      $display("[TB] start pulsed while busy");
      applyStimulus(8'h60, 5'd10);
      while (cyc < last_l + 5) @(negedge clk);
      start      = 1'b1;
      base_addr  = 8'hAA;
      rows_valid = 5'd2;
      @(negedge clk);
      start = 1'b0;
      waitIdle();

      $display("[TB] reset mid-load");
      applyStimulus(8'h30, 5'd16);
      while (cyc < last_l + 7) @(negedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      rd_q.delete();
      win_q.delete();
      done_q.delete();
      busy_lo.delete();
      busy_hi.delete();
      #1;
      checkAllZero("async_reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      applyStimulus(8'h30, 5'd16);
      waitIdle();

      $display("[TB] PE chain contents");
      mixed = 1'b1;
      applyStimulus(8'h10, 5'd16);
      waitIdle();
      checkChain(8'h10, 16);
      applyStimulus(8'h80, 5'd5);
      waitIdle();
      checkChain(8'h80, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
